// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- write-back queue in front of the register unit's write port.
//
// Buffers pending register writes {rd, data} in a circular buffer. It drains
// one write per cycle into the register unit unless another writer holds the
// port. It also exposes the youngest queued value for rs1/rs2 as forwarding
// hits.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//   XLEN      data width
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake (in_ready = !full)
//   in_rd, in_data        destination index and value of the request
//   wb_hold               write port claimed elsewhere; no drain this cycle
//   rs1, rs2              decode source indices to search
//   fwdN_hit, fwdN_data   queued-write forwarding result per source port
//   rd, DataWr, RUWr      register-unit write port (head entry)
//   count                 current occupancy
// ---------------------------------------------------------------------------
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rd,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   wb_hold,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [XLEN-1:0]        fwd1_data,
  output logic [XLEN-1:0]        fwd2_data,
  output logic [4:0]             rd,
  output logic [XLEN-1:0]        DataWr,
  output logic                   RUWr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      rd_mem_r   [DEPTH];
  logic [XLEN-1:0] data_mem_r [DEPTH];
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;

  logic full_s;
  logic empty_s;
  logic accept_s;
  logic store_s;
  logic drain_s;

  // Full ignores any same-cycle drain, so in_ready depends on registered state only.
  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == '0);
  assign accept_s = in_valid && !full_s;
  // A write to x0 completes the handshake but is never stored.
  assign store_s  = accept_s && (in_rd != 5'd0);
  assign drain_s  = !empty_s && !wb_hold;

  assign in_ready = !full_s;
  assign RUWr     = drain_s;
  assign count    = count_r;
  assign rd       = empty_s ? 5'd0 : rd_mem_r[head_r];
  assign DataWr   = empty_s ? {XLEN{1'b0}} : data_mem_r[head_r];

  // Next occupancy from store/drain pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({store_s, drain_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; reset discards all pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (drain_s) begin
        head_r <= head_r + AW'(1);
      end
      if (store_s) begin
        tail_r <= tail_r + AW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (store_s) begin
      rd_mem_r[tail_r]   <= in_rd;
      data_mem_r[tail_r] <= in_data;
    end
  end

  // Forwarding search from oldest to youngest, so later matches override earlier ones.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = {XLEN{1'b0}};
    fwd2_data = {XLEN{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      logic occ;
      logic m1;
      logic m2;
      occ = (CW'(i) < count_r);
      m1  = occ && (rs1 != 5'd0) && (rd_mem_r[head_r + AW'(i)] == rs1);
      m2  = occ && (rs2 != 5'd0) && (rd_mem_r[head_r + AW'(i)] == rs2);
      fwd1_hit  = fwd1_hit | m1;
      fwd2_hit  = fwd2_hit | m2;
      fwd1_data = m1 ? data_mem_r[head_r + AW'(i)] : fwd1_data;
      fwd2_data = m2 ? data_mem_r[head_r + AW'(i)] : fwd2_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue -- self-checking bench for wb_queue.
// Directed table of per-cycle vectors, a mid-operation reset sequence, and
// randomized traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            wb_hold;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
  logic [4:0]      rd;
  logic [XLEN-1:0] DataWr;
  logic            RUWr;
  logic [2:0]      count;

  int errors = 0;
  int checks = 0;

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_hold(wb_hold), .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rdi;
    logic [31:0] din;
    logic        hold;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_ready;
    logic        e_ruwr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_count;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] rdi, input logic [31:0] din,
                     input logic hold, input logic [4:0] s1, input logic [4:0] s2,
                     input logic e_ready, input logic e_ruwr, input logic [4:0] e_rd,
                     input logic [31:0] e_data, input logic [2:0] e_count,
                     input logic e_h1, input logic [31:0] e_d1,
                     input logic e_h2, input logic [31:0] e_d2);
    vec_t r;
    r.v = v; r.rdi = rdi; r.din = din; r.hold = hold; r.s1 = s1; r.s2 = s2;
    r.e_ready = e_ready; r.e_ruwr = e_ruwr; r.e_rd = e_rd; r.e_data = e_data;
    r.e_count = e_count; r.e_h1 = e_h1; r.e_d1 = e_d1; r.e_h2 = e_h2; r.e_d2 = e_d2;
    tbl.push_back(r);
  endtask

  // Expected outputs straight from the queue contents and current inputs.
  task automatic check_model(input string tag);
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        h1;
    logic        h2;
    logic [31:0] d1;
    logic [31:0] d2;
    int n;
    n = mq.size();
    erd = 5'd0; edata = 32'd0;
    if (n != 0) begin
      erd = mq[0].rd; edata = mq[0].data;
    end
    h1 = 1'b0; h2 = 1'b0; d1 = 32'd0; d2 = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (rs1 != 5'd0 && mq[i].rd == rs1) begin h1 = 1'b1; d1 = mq[i].data; end
      if (rs2 != 5'd0 && mq[i].rd == rs2) begin h2 = 1'b1; d2 = mq[i].data; end
    end
    chk({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, (n != DEPTH)});
    chk({tag, ".RUWr"},      {31'd0, RUWr},     {31'd0, (n != 0) && !wb_hold});
    chk({tag, ".rd"},        {27'd0, rd},       {27'd0, erd});
    chk({tag, ".DataWr"},    DataWr,            edata);
    chk({tag, ".count"},     {29'd0, count},    32'(n));
    chk({tag, ".fwd1_hit"},  {31'd0, fwd1_hit}, {31'd0, h1});
    chk({tag, ".fwd1_data"}, fwd1_data,         d1);
    chk({tag, ".fwd2_hit"},  {31'd0, fwd2_hit}, {31'd0, h2});
    chk({tag, ".fwd2_data"}, fwd2_data,         d2);
  endtask

  // Advance the reference model across one rising edge.
  task automatic model_edge();
    bit acc;
    bit drn;
    ent_t e;
    acc = in_valid && (mq.size() != DEPTH);
    drn = (mq.size() != 0) && !wb_hold;
    if (drn) mq.delete(0);
    if (acc && in_rd != 5'd0) begin
      e.rd = in_rd; e.data = in_data;
      mq.push_back(e);
    end
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_row(input int k, input vec_t r);
    string t;
    t = $sformatf("row%0d", k);
    chk({t, ".in_ready"},  {31'd0, in_ready}, {31'd0, r.e_ready});
    chk({t, ".RUWr"},      {31'd0, RUWr},     {31'd0, r.e_ruwr});
    chk({t, ".rd"},        {27'd0, rd},       {27'd0, r.e_rd});
    chk({t, ".DataWr"},    DataWr,            r.e_data);
    chk({t, ".count"},     {29'd0, count},    {29'd0, r.e_count});
    chk({t, ".fwd1_hit"},  {31'd0, fwd1_hit}, {31'd0, r.e_h1});
    chk({t, ".fwd1_data"}, fwd1_data,         r.e_d1);
    chk({t, ".fwd2_hit"},  {31'd0, fwd2_hit}, {31'd0, r.e_h2});
    chk({t, ".fwd2_data"}, fwd2_data,         r.e_d2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_data = 32'd0;
    wb_hold = 1'b0; rs1 = 5'd0; rs2 = 5'd0;

    // Vectors: inputs applied for one cycle, outputs expected during that cycle.
    //   v  rd   data          hold rs1 rs2  rdy ruwr rd   data          cnt h1  d1            h2  d2
    // single write
    add(1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 5, 0,  1, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 0, 32'h0);
    add(0, 0, 32'h0,        0, 5, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    // fill under hold, backpressure, then drain in order
    add(1, 1, 32'h11,       1, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(1, 2, 32'h22,       1, 0, 0,  1, 0, 1, 32'h11,       1, 0, 32'h0,        0, 32'h0);
    add(1, 3, 32'h33,       1, 0, 0,  1, 0, 1, 32'h11,       2, 0, 32'h0,        0, 32'h0);
    add(1, 4, 32'h44,       1, 0, 0,  1, 0, 1, 32'h11,       3, 0, 32'h0,        0, 32'h0);
    add(1, 5, 32'h55,       1, 3, 5,  0, 0, 1, 32'h11,       4, 1, 32'h33,       0, 32'h0);
    add(1, 5, 32'h55,       0, 0, 0,  0, 1, 1, 32'h11,       4, 0, 32'h0,        0, 32'h0);
    add(1, 5, 32'h55,       0, 0, 0,  1, 1, 2, 32'h22,       3, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0,  1, 1, 3, 32'h33,       3, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0,  1, 1, 4, 32'h44,       2, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0,  1, 1, 5, 32'h55,       1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    // forwarding picks youngest; drained entry still hits
    add(1, 7, 32'hA,        1, 7, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(1, 7, 32'hB,        1, 7, 7,  1, 0, 7, 32'hA,        1, 1, 32'hA,        1, 32'hA);
    add(0, 0, 32'h0,        1, 7, 0,  1, 0, 7, 32'hA,        2, 1, 32'hB,        0, 32'h0);
    add(0, 0, 32'h0,        0, 7, 0,  1, 1, 7, 32'hA,        2, 1, 32'hB,        0, 32'h0);
    add(0, 0, 32'h0,        0, 7, 0,  1, 1, 7, 32'hB,        1, 1, 32'hB,        0, 32'h0);
    add(0, 0, 32'h0,        0, 7, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    // x0 request is accepted and dropped
    add(1, 0, 32'h1234,     0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_row(-1, tbl[13]);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      in_valid = tbl[k].v; in_rd = tbl[k].rdi; in_data = tbl[k].din;
      wb_hold = tbl[k].hold; rs1 = tbl[k].s1; rs2 = tbl[k].s2;
      @(negedge clk);
      check_row(k, tbl[k]);
      end_cycle();
    end

    // Reset in the middle of a cycle with three writes pending.
    wb_hold = 1'b1; rs1 = 5'd9; rs2 = 5'd11;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(9 + i); in_data = 32'h900 + 32'(i);
      @(negedge clk);
      check_model("mrfill");
      end_cycle();
    end
    in_valid = 1'b0;
    chk("mr.count_before", {29'd0, count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check_model("mr.async");
    @(negedge clk);
    rst_n = 1'b1;
    wb_hold = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_model("mr.after");
      end_cycle();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_rd    = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      wb_hold  = ($urandom_range(0, 99) < 35);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      @(negedge clk);
      check_model("rnd");
      end_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
